// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: imem request/response, IF/ID handshake toward decode, redirect from branch resolution.
interface fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    modport master (
        output imem_req_valid, imem_addr, id_valid, id_instr, id_pc_plus4,
        input  imem_req_ready, imem_resp_valid, imem_rdata, id_ready,
               redirect_valid, redirect_target
    );

    modport slave (
        input  imem_req_valid, imem_addr, id_valid, id_instr, id_pc_plus4,
        output imem_req_ready, imem_resp_valid, imem_rdata, id_ready,
               redirect_valid, redirect_target
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request FSM, one-entry skid buffer, IF/ID register.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
`endif
    fetch_if.master     bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        drop;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic        id_valid_q;
    logic [31:0] id_instr_q;
    logic [31:0] id_pc4_q;

    logic        req_fire;
    logic        resp_in;
    logic        resp_live;
    logic        consume;
    logic [31:0] redir_pc;
    logic        unused_tgt_bits;

    assign req_fire  = (state == REQ) & ~skid_valid & bus.imem_req_ready;
    assign resp_in   = (state == WAIT) & bus.imem_resp_valid;
    assign resp_live = resp_in & ~drop & ~bus.redirect_valid;
    assign consume   = id_valid_q & bus.id_ready;
    assign redir_pc  = {bus.redirect_target[31:2], 2'b00};
    assign unused_tgt_bits = ^bus.redirect_target[1:0];

    assign bus.imem_req_valid = (state == REQ) & ~skid_valid;
    assign bus.imem_addr      = pc;
    assign bus.id_valid       = id_valid_q;
    assign bus.id_instr       = id_instr_q;
    assign bus.id_pc_plus4    = id_pc4_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc4   <= '0;
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc4_q   <= '0;
        end else if (bus.redirect_valid) begin
            pc         <= redir_pc;
            id_valid_q <= 1'b0;
            skid_valid <= 1'b0;
            case (state)
                IDLE: state <= REQ;
                REQ: if (req_fire) begin
                    state <= WAIT;
                    drop  <= 1'b1;
                end
                // A response landing with the redirect is the outstanding one: nothing left to drop.
                WAIT: if (bus.imem_resp_valid) begin
                    state <= REQ;
                    drop  <= 1'b0;
                end else begin
                    drop  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: if (req_fire) begin
                    state <= WAIT;
                    pc    <= pc + 32'd4;
                end
                WAIT: if (bus.imem_resp_valid) begin
                    state <= REQ;
                    drop  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // pc already points past the outstanding request, so it equals request address + 4.
            if (resp_live) begin
                if (!id_valid_q || consume) begin
                    id_valid_q <= 1'b1;
                    id_instr_q <= bus.imem_rdata;
                    id_pc4_q   <= pc;
                end else begin
                    skid_valid <= 1'b1;
                    skid_instr <= bus.imem_rdata;
                    skid_pc4   <= pc;
                end
            end else if (consume) begin
                if (skid_valid) begin
                    id_instr_q <= skid_instr;
                    id_pc4_q   <= skid_pc4;
                    skid_valid <= 1'b0;
                end else begin
                    id_valid_q <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flush_inc;
    assign flush_inc = {31'b0, bus.redirect_valid & id_valid_q}
                     + {31'b0, bus.redirect_valid & skid_valid}
                     + {31'b0, resp_in & (drop | bus.redirect_valid)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (id_valid_q & ~bus.id_ready)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            perf_flush_count <= perf_flush_count + flush_inc;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized memory/decode/redirect traffic
// checked against an architectural model (program-order PC stream restarted at each redirect).
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wrst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus();
    fetch_if wbus();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] ps, pf, wps, wpf;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef FETCH_PERF_CNT_EN
        .perf_stall_cycles(ps), .perf_flush_count(pf),
`endif
        .bus(bus)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(wrst_n),
`ifdef FETCH_PERF_CNT_EN
        .perf_stall_cycles(wps), .perf_flush_count(wpf),
`endif
        .bus(wbus)
    );

    int vec = 0;
    int errs = 0;

    // model / memory state
    logic        pending;
    logic [31:0] pend_addr;
    int          lat;
    int          lat_min, lat_max;
    logic        rdy_always;
    int          idr_mode;          // 0: hold low, 1: hold high, 2: random
    logic        redir_force, redir_rand;
    logic [31:0] force_tgt;
    logic [31:0] exp_pc, exp_req, last_pc4;
    logic        exp_flush, track_gap;
    int          n_acc, n_del, cyc, last_acc, stall_ref;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_rdata = '0;
        bus.id_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
        pending = 1'b0; lat = 0; exp_pc = '0; exp_req = '0; exp_flush = 1'b0;
        n_acc = 0; n_del = 0; cyc = 0; last_acc = 0; stall_ref = 0; redir_force = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_id_valid", bus.id_valid, 0);
        chk("rst_id_instr", bus.id_instr, 0);
        chk("rst_id_pc4", bus.id_pc_plus4, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_after_reset", bus.imem_req_valid, 1);
    endtask

    // One cycle: observe at negedge, drive inputs, update the model for the coming posedge.
    task automatic step();
        logic [31:0] tgt;
        @(negedge clk);
        if (exp_flush) chk("id_valid_after_redirect", bus.id_valid, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall", ps, stall_ref);
`endif
        if (pending && lat == 0) begin
            bus.imem_resp_valid = 1'b1; bus.imem_rdata = mem(pend_addr); pending = 1'b0;
        end else begin
            bus.imem_resp_valid = 1'b0; bus.imem_rdata = $urandom;
            if (pending) lat--;
        end
        bus.imem_req_ready = rdy_always ? 1'b1 : 1'($urandom_range(0, 1));
        bus.id_ready = (idr_mode == 2) ? 1'($urandom_range(0, 1)) : (idr_mode == 1);
        tgt = redir_force ? force_tgt : $urandom;
        bus.redirect_valid = redir_force || (redir_rand && $urandom_range(0, 11) == 0);
        bus.redirect_target = tgt;
        exp_flush = bus.redirect_valid;
`ifdef FETCH_PERF_CNT_EN
        if (bus.id_valid && !bus.id_ready) stall_ref++;
`endif
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_addr, exp_req);
            chk("one_outstanding", pending, 0);
            if (track_gap && n_acc > 0) chk("accept_gap", cyc - last_acc, 2);
            pending = 1'b1; pend_addr = bus.imem_addr;
            lat = $urandom_range(lat_min, lat_max);
            n_acc++; last_acc = cyc; exp_req += 32'd4;
        end
        if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
            chk("id_instr", bus.id_instr, mem(exp_pc));
            chk("id_pc_plus4", bus.id_pc_plus4, exp_pc + 32'd4);
            last_pc4 = bus.id_pc_plus4;
            exp_pc += 32'd4; n_del++;
        end
        if (bus.redirect_valid) begin
            exp_pc = {tgt[31:2], 2'b00};
            exp_req = exp_pc;
        end
        cyc++;
    endtask

    initial begin
        int n0;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] pf0;
`endif
        // RESET_PC wrap instance, driven by hand
        wbus.imem_req_ready = 1'b1; wbus.imem_resp_valid = 1'b0; wbus.imem_rdata = '0;
        wbus.id_ready = 1'b1; wbus.redirect_valid = 1'b0; wbus.redirect_target = '0;
        repeat (2) @(negedge clk);
        chk("wrap_rst_addr", wbus.imem_addr, 32'hFFFF_FFFC);
        wrst_n = 1'b1;
        @(negedge clk);
        chk("wrap_req_valid", wbus.imem_req_valid, 1);
        chk("wrap_addr0", wbus.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        wbus.imem_resp_valid = 1'b1; wbus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        wbus.imem_resp_valid = 1'b0;
        chk("wrap_id_valid", wbus.id_valid, 1);
        chk("wrap_id_instr", wbus.id_instr, 32'hDEAD_BEEF);
        chk("wrap_pc4", wbus.id_pc_plus4, 32'h0);
        chk("wrap_addr1", wbus.imem_addr, 32'h0);
        wrst_n = 1'b0;

        // Streaming with 1-cycle memory: requests on alternate cycles, in-order delivery
        rdy_always = 1'b1; lat_min = 0; lat_max = 0; idr_mode = 1; redir_rand = 1'b0;
        track_gap = 1'b1; force_tgt = '0;
        do_reset();
        repeat (10) step();
        chk("stream_deliveries", 32'(n_del >= 3), 1);
        track_gap = 1'b0;

        // Decode stall: IF/ID and skid fill, request held; release drains in order
        do_reset();
        idr_mode = 0;
        repeat (6) step();
        chk("stall_id_valid", bus.id_valid, 1);
        chk("stall_req_held", bus.imem_req_valid, 0);
`ifdef FETCH_PERF_CNT_EN
        pf0 = pf;
        force_tgt = 32'h40; redir_force = 1'b1; step(); redir_force = 1'b0;
        step();
        chk("perf_flush_two", pf, pf0 + 32'd2);
        do_reset();
        idr_mode = 0;
        repeat (6) step();
`endif
        idr_mode = 1;
        repeat (6) step();
        chk("drain_count", 32'(n_del >= 2), 1);

        // Redirect while waiting on memory
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 10 && !pending; i++) step();
        chk("reached_wait", pending, 1);
        n0 = n_del;
        force_tgt = 32'h103; redir_force = 1'b1; step(); redir_force = 1'b0;
        for (int i = 0; i < 40 && n_del == n0; i++) step();
        chk("redirect_pc4", last_pc4, 32'h104);

        // Redirect coinciding with a response and id_ready
        lat_min = 0; lat_max = 0;
        for (int i = 0; i < 20 && !(pending && lat == 0); i++) step();
        chk("resp_due", pending && lat == 0, 1);
        force_tgt = 32'h200; redir_force = 1'b1; step(); redir_force = 1'b0;
        n0 = n_del;
        repeat (8) step();
        chk("after_collide_deliveries", 32'(n_del > n0), 1);

        // Randomized traffic, entered via a reset while a request is in flight
        rdy_always = 1'b0; lat_min = 0; lat_max = 3; idr_mode = 2; redir_rand = 1'b1;
        do_reset();
        repeat (600) step();
        chk("random_deliveries", 32'(n_del > 20), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
